// File: rtl/hs32_alu_seq_if.sv
// hs32_alu_seq_if: request/response bundle for the multi-cycle HS32 ALU.
//   master: drives the request (valid_i, operands, op, controls, abort_i)
//           and observes ready_o, valid_o, out_o, flags_o.
//   slave : the ALU side of the same signals.
interface hs32_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [2:0]       op_i;
    logic             neg_i;
    logic             sub_i;
    logic             cen_i;
    logic             fwe_i;
    logic             abort_i;
    logic             valid_o;
    logic [WIDTH-1:0] out_o;
    logic [3:0]       flags_o;

    modport master (
        output valid_i, a_i, b_i, op_i, neg_i, sub_i, cen_i, fwe_i, abort_i,
        input  ready_o, valid_o, out_o, flags_o
    );

    modport slave (
        input  valid_i, a_i, b_i, op_i, neg_i, sub_i, cen_i, fwe_i, abort_i,
        output ready_o, valid_o, out_o, flags_o
    );
endinterface

// File: rtl/hs32_alu_seq.sv
// hs32_alu_seq: multi-cycle HS32 ALU with valid/ready handshake.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : slave side of hs32_alu_seq_if
//           request : valid_i, a_i, b_i, op_i, neg_i, sub_i, cen_i, fwe_i, abort_i
//           response: ready_o (not BUSY), valid_o (DONE pulse),
//                     out_o (registered result), flags_o (NZCV)
// ADD/AND/OR/XOR finish on the accept edge; shifts take one cycle per bit;
// MUL is a WIDTH-cycle shift-add keeping the low half of the product.
module hs32_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic         clk,
    input logic         reset,
    hs32_alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000, OP_AND = 3'b001, OP_OR  = 3'b010,
                           OP_XOR = 3'b011, OP_SHL = 3'b100, OP_SHR = 3'b101,
                           OP_ASR = 3'b110, OP_MUL = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, out_q, out_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             fwe_q, fwe_d;
    logic [3:0]       flags_q, flags_d;

    // Accept-time arithmetic, evaluated straight from the request inputs.
    logic [WIDTH-1:0] b_eff;
    logic             ci;
    logic [WIDTH:0]   sum;
    logic             v_add;
    logic             accept;

    // Completion bundle shared by every path that enters DONE.
    logic             fin;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, fwe_use;

    // One-bit shift step of the in-flight shift and its shifted-out bit.
    logic [WIDTH-1:0] step_a;
    logic             step_c;
    logic [WIDTH-1:0] mul_acc;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    assign accept = bus.valid_i && (state_q != BUSY);
    assign b_eff  = bus.b_i ^ {WIDTH{bus.neg_i}};
    // Carry-in reads the registered flags, so an op accepted in DONE sees
    // the flags written by the op that just completed.
    assign ci     = (flags_q[1] & bus.cen_i) ^ bus.sub_i;
    assign sum    = {1'b0, bus.a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ci};
    assign v_add  = (bus.a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.a_i[WIDTH-1]);

    always_comb begin
        step_a = a_q;
        step_c = 1'b0;
        case (op_q)
            OP_SHL:  begin step_a = {a_q[WIDTH-2:0], 1'b0};      step_c = a_q[WIDTH-1]; end
            OP_SHR:  begin step_a = {1'b0, a_q[WIDTH-1:1]};      step_c = a_q[0];       end
            OP_ASR:  begin step_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; step_c = a_q[0];    end
            default: begin step_a = a_q;                         step_c = 1'b0;         end
        endcase
    end

    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fwe_d   = fwe_q;
        out_d   = out_q;
        flags_d = flags_q;
        fin     = 1'b0;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        fwe_use = fwe_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d    = bus.op_i;
                    fwe_d   = bus.fwe_i;
                    fwe_use = bus.fwe_i;
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    acc_d   = '0;
                    case (bus.op_i)
                        OP_ADD: begin
                            fin = 1'b1; res = sum[WIDTH-1:0];
                            res_c = sum[WIDTH]; res_v = v_add;
                        end
                        OP_AND: begin fin = 1'b1; res = bus.a_i & b_eff; end
                        OP_OR:  begin fin = 1'b1; res = bus.a_i | b_eff; end
                        OP_XOR: begin fin = 1'b1; res = bus.a_i ^ b_eff; end
                        OP_MUL: begin
                            cnt_d   = (SHW+1)'(WIDTH);
                            state_d = BUSY;
                        end
                        default: begin
                            // Zero-length shift completes at once with C cleared.
                            if (bus.b_i[SHW-1:0] == '0) begin
                                fin = 1'b1; res = bus.a_i;
                            end else begin
                                cnt_d   = {1'b0, bus.b_i[SHW-1:0]};
                                state_d = BUSY;
                            end
                        end
                    endcase
                end
            end
            BUSY: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_d = mul_acc;
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                        b_d   = {1'b0, b_q[WIDTH-1:1]};
                        res   = mul_acc;
                    end else begin
                        a_d   = step_a;
                        res   = step_a;
                        res_c = step_c;
                    end
                    fin = (cnt_q == (SHW+1)'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d = DONE;
            out_d   = res;
            if (fwe_use) flags_d = mk_flags(res, res_c, res_v);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            fwe_q   <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fwe_q   <= fwe_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign bus.ready_o = (state_q != BUSY);
    assign bus.valid_o = (state_q == DONE);
    assign bus.out_o   = out_q;
    assign bus.flags_o = flags_q;
endmodule

// File: tb/tb_hs32_alu_seq.sv
// Directed bench for hs32_alu_seq with hand-computed expected values.
module tb_hs32_alu_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hs32_alu_seq_if #(.WIDTH(W)) bus();

    hs32_alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.op_i = 3'b000;
        bus.neg_i = 1'b0; bus.sub_i = 1'b0; bus.cen_i = 1'b0;
        bus.fwe_i = 1'b0; bus.abort_i = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic neg, input logic sub, input logic cen, input logic fwe);
        bus.valid_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
        bus.neg_i = neg; bus.sub_i = sub; bus.cen_i = cen; bus.fwe_i = fwe;
    endtask

    // Issues one op, then waits (bounded) for valid_o. lat is the cycle index
    // of valid_o counted from the accept edge (-1 on timeout); rlow counts
    // cycles with ready_o low before completion. Returns in the valid_o cycle.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic neg, input logic sub, input logic cen, input logic fwe,
                          output int lat, output int rlow);
        drive(op, a, b, neg, sub, cen, fwe);
        tick();
        idle_inputs();
        lat = -1;
        rlow = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.valid_o) begin
                lat = k;
                break;
            end
            if (!bus.ready_o) rlow++;
            tick();
        end
    endtask

    task automatic test_reset();
        int lat, rlow;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        run_op(3'b000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (bus.out_o !== 32'h0) begin n_err++; $display("FAIL reset_out got %h want 00000000", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", bus.flags_o); end
        n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
        tick();
        #2;
        reset = 1'b0;
        tick();
        n_vec++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
    endtask

    task automatic test_subtract();
        drive(3'b000, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        n_vec++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL sub_valid got %b want 1", bus.valid_o); end
        n_vec++; if (bus.out_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_out got %h want fffffffe", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b1000) begin n_err++; $display("FAIL sub_flags got %b want 1000", bus.flags_o); end
        // Back-to-back accept while in DONE.
        drive(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_inputs();
        n_vec++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", bus.valid_o); end
        n_vec++; if (bus.out_o !== 32'h8000_0000) begin n_err++; $display("FAIL b2b_out got %h want 80000000", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b1001) begin n_err++; $display("FAIL b2b_flags got %b want 1001", bus.flags_o); end
        tick();
        n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_pulse got %b want 0", bus.valid_o); end
    endtask

    task automatic test_carry_chain();
        int lat, rlow;
        run_op(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (bus.out_o !== 32'h0) begin n_err++; $display("FAIL carry_out got %h want 00000000", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0110) begin n_err++; $display("FAIL carry_flags got %b want 0110", bus.flags_o); end
        run_op(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, lat, rlow);
        n_vec++; if (bus.out_o !== 32'h1) begin n_err++; $display("FAIL cen_out got %h want 00000001", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0000) begin n_err++; $display("FAIL cen_flags got %b want 0000", bus.flags_o); end
        tick();
    endtask

    task automatic test_logic_fwe();
        int lat, rlow;
        // Flags are 0000 here; fwe=0 must leave them alone.
        run_op(3'b001, 32'hF0F0_1234, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, lat, rlow);
        n_vec++; if (bus.out_o !== 32'hF0F0_0000) begin n_err++; $display("FAIL andn_out got %h want f0f00000", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0000) begin n_err++; $display("FAIL andn_flags_held got %b want 0000", bus.flags_o); end
        run_op(3'b011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (bus.out_o !== 32'h0) begin n_err++; $display("FAIL xor_out got %h want 00000000", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0100) begin n_err++; $display("FAIL xor_flags got %b want 0100", bus.flags_o); end
        run_op(3'b010, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (bus.out_o !== 32'h8000_0001) begin n_err++; $display("FAIL or_out got %h want 80000001", bus.out_o); end
        tick();
    endtask

    task automatic test_shifts();
        int lat, rlow;
        run_op(3'b100, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL shl1_lat got %0d want 2", lat); end
        n_vec++; if (rlow !== 1) begin n_err++; $display("FAIL shl1_rdylow got %0d want 1", rlow); end
        n_vec++; if (bus.out_o !== 32'h0000_0002) begin n_err++; $display("FAIL shl1_out got %h want 00000002", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0010) begin n_err++; $display("FAIL shl1_flags got %b want 0010", bus.flags_o); end
        tick();
        run_op(3'b100, 32'h8000_0001, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL shl0_lat got %0d want 1", lat); end
        n_vec++; if (bus.out_o !== 32'h8000_0001) begin n_err++; $display("FAIL shl0_out got %h want 80000001", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b1000) begin n_err++; $display("FAIL shl0_flags got %b want 1000", bus.flags_o); end
        tick();
        run_op(3'b101, 32'h8000_0006, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL shr2_lat got %0d want 3", lat); end
        n_vec++; if (bus.out_o !== 32'h2000_0001) begin n_err++; $display("FAIL shr2_out got %h want 20000001", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0010) begin n_err++; $display("FAIL shr2_flags got %b want 0010", bus.flags_o); end
        tick();
        run_op(3'b110, 32'h8000_0000, 32'd31, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (lat !== 32) begin n_err++; $display("FAIL asr_lat got %0d want 32", lat); end
        n_vec++; if (rlow !== 31) begin n_err++; $display("FAIL asr_rdylow got %0d want 31", rlow); end
        n_vec++; if (bus.out_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL asr_out got %h want ffffffff", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b1000) begin n_err++; $display("FAIL asr_flags got %b want 1000", bus.flags_o); end
        tick();
    endtask

    task automatic test_mul_abort();
        int lat, rlow;
        logic seen_valid;
        run_op(3'b111, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mul_lat got %0d want 33", lat); end
        n_vec++; if (rlow !== 32) begin n_err++; $display("FAIL mul_rdylow got %0d want 32", rlow); end
        n_vec++; if (bus.out_o !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mul_out got %h want fffffffd", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b1000) begin n_err++; $display("FAIL mul_flags got %b want 1000", bus.flags_o); end
        tick();
        run_op(3'b111, 32'h0001_0003, 32'h0000_0105, 1'b0, 1'b0, 1'b0, 1'b0, lat, rlow);
        n_vec++; if (bus.out_o !== 32'h0105_030F) begin n_err++; $display("FAIL mul2_out got %h want 0105030f", bus.out_o); end
        tick();
        // Aborted MUL whose result (15, flags 0000) would differ from the held one.
        run_op(3'b111, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, lat, rlow);
        tick();
        drive(3'b111, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_inputs();
        repeat (9) tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        n_vec++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", bus.ready_o); end
        seen_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            seen_valid |= bus.valid_o;
            tick();
        end
        n_vec++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b want 0", seen_valid); end
        n_vec++; if (bus.out_o !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL abort_out got %h want fffffffd", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b1000) begin n_err++; $display("FAIL abort_flags got %b want 1000", bus.flags_o); end
    endtask

    task automatic test_reset_busy();
        drive(3'b111, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_inputs();
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL rstbusy_ready got %b want 1", bus.ready_o); end
        n_vec++; if (bus.out_o !== 32'h0) begin n_err++; $display("FAIL rstbusy_out got %h want 00000000", bus.out_o); end
        n_vec++; if (bus.flags_o !== 4'b0000) begin n_err++; $display("FAIL rstbusy_flags got %b want 0000", bus.flags_o); end
        tick();
        reset = 1'b0;
        repeat (40) tick();
        n_vec++; if (bus.out_o !== 32'h0) begin n_err++; $display("FAIL rstbusy_after got %h want 00000000", bus.out_o); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_subtract();
        test_carry_chain();
        test_logic_fwe();
        test_shifts();
        test_mul_abort();
        test_reset_busy();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
